// File: rtl/ierl78_orbus_icedop_v2.sv
// ICEDOP N-source merge (OR / fixed priority / round-robin) with collision accounting.
// Latency 1 cycle, fully registered; no backpressure, a new result is produced every cycle.
module ierl78_orbus_icedop_v2 #(
    parameter int NSRC = 2,
    parameter int DW   = 32,
    parameter int CW   = 8
) (
    input  logic                 BASECK,
    input  logic                 RESETB,
    input  logic [NSRC*DW-1:0]   ICEDOPIN,
    input  logic [NSRC-1:0]      ICEDOPVLD,
    input  logic [1:0]           MODE,
    input  logic                 CLRERR,
    output logic [DW-1:0]        ICEDOP,
    output logic                 ICEDOPV,
    output logic [NSRC-1:0]      GRANT,
    output logic                 COLL,
    output logic [CW-1:0]        COLLCNT
);

    localparam int PW = (NSRC > 2) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_PRI = 2'b01,
        MODE_RR  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    mode_e           mode;
    logic [DW-1:0]   src_dat [NSRC];
    logic            any_vld;
    logic            multi_vld;

    logic [DW-1:0]   or_dat;
    logic            or_coll;

    logic [PW-1:0]   pri_idx;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_idx;
    logic [PW-1:0]   rr_cand;
    logic [PW-1:0]   rr_nxt;
    logic            rr_hit;

    logic [DW-1:0]   nxt_dat;
    logic [NSRC-1:0] nxt_gnt;
    logic            coll_ev;
    logic            coll_nxt;
    logic [CW-1:0]   cnt_nxt;

    assign mode      = mode_e'(MODE);
    assign any_vld   = |ICEDOPVLD;
    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign multi_vld = |(ICEDOPVLD & (ICEDOPVLD - NSRC'(1)));

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_dat[i] = ICEDOPIN[i*DW +: DW] & {DW{ICEDOPVLD[i]}};
        end
    end

    // A bit already present in the running OR means some earlier source overlaps this one.
    always_comb begin
        or_dat  = '0;
        or_coll = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (|(or_dat & src_dat[i])) begin
                or_coll = 1'b1;
            end
            or_dat = or_dat | src_dat[i];
        end
    end

    always_comb begin
        pri_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (ICEDOPVLD[i]) begin
                pri_idx = PW'(i);
            end
        end
    end

    always_comb begin
        rr_idx  = rr_ptr;
        rr_hit  = 1'b0;
        rr_cand = '0;
        for (int j = 0; j < NSRC; j++) begin
            rr_cand = PW'((int'(rr_ptr) + j) % NSRC);
            if (!rr_hit && ICEDOPVLD[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    assign rr_nxt = (int'(rr_idx) == NSRC - 1) ? '0 : rr_idx + PW'(1);

    always_comb begin
        nxt_dat = '0;
        nxt_gnt = '0;
        coll_ev = 1'b0;
        case (mode)
            MODE_PRI: begin
                nxt_dat = src_dat[pri_idx];
                nxt_gnt = NSRC'(1) << pri_idx;
                coll_ev = multi_vld;
            end
            MODE_RR: begin
                nxt_dat = src_dat[rr_idx];
                nxt_gnt = NSRC'(1) << rr_idx;
                coll_ev = multi_vld;
            end
            default: begin
                nxt_dat = or_dat;
                nxt_gnt = ICEDOPVLD;
                coll_ev = or_coll;
            end
        endcase
        if (!any_vld) begin
            nxt_dat = '0;
            nxt_gnt = '0;
        end
    end

    // A collision in the clearing cycle counts as the first event after the clear.
    always_comb begin
        coll_nxt = COLL;
        cnt_nxt  = COLLCNT;
        if (coll_ev) begin
            coll_nxt = 1'b1;
            if (CLRERR) begin
                cnt_nxt = CW'(1);
            end else if (!(&COLLCNT)) begin
                cnt_nxt = COLLCNT + CW'(1);
            end
        end else if (CLRERR) begin
            coll_nxt = 1'b0;
            cnt_nxt  = '0;
        end
    end

    always_ff @(posedge BASECK or negedge RESETB) begin
        if (!RESETB) begin
            ICEDOP  <= '0;
            ICEDOPV <= 1'b0;
            GRANT   <= '0;
            COLL    <= 1'b0;
            COLLCNT <= '0;
            rr_ptr  <= '0;
        end else begin
            ICEDOP  <= nxt_dat;
            ICEDOPV <= any_vld;
            GRANT   <= nxt_gnt;
            COLL    <= coll_nxt;
            COLLCNT <= cnt_nxt;
            if (mode == MODE_RR && any_vld) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

endmodule

// File: doc/ierl78_orbus_icedop_v2.md
Name: ierl78_orbus_icedop_v2

Overview:
Parametrised, registered successor to the two-input ICEDOP OR bus. It merges NSRC ICE data-output sources of DW bits each onto one ICEDOP bus feeding the ICE interface. Each source has a valid qualifier. The merge policy is run-time selectable: masked OR, fixed priority, or round-robin. The block also detects source contention, reporting it through a sticky flag and a saturating counter.

Parameters:
NSRC, 2, number of sources (legal 2..8)
DW, 32, data width per source
CW, 8, collision counter width

Ports:
BASECK  input  1  clock; all state on rising edge
RESETB  input  1  reset, asynchronous, active-low
ICEDOPIN  input  NSRC*DW  source data; source i occupies bits [i*DW+DW-1 : i*DW]
ICEDOPVLD  input  NSRC  per-source valid; bit i qualifies source i
MODE  input  2  00 = OR merge; 01 = fixed priority; 10 = round-robin; 11 = reserved, treated as 00
CLRERR  input  1  synchronous clear of COLL and COLLCNT
ICEDOP  output  DW  merged data, registered
ICEDOPV  output  1  ICEDOP holds valid data, registered
GRANT  output  NSRC  one-hot index of the granted source in modes 01/10; equals registered ICEDOPVLD in OR mode
COLL  output  1  sticky collision flag
COLLCNT  output  CW  saturating collision count

Behaviour:
- Async reset (RESETB=0): ICEDOP=0, ICEDOPV=0, GRANT=0, COLL=0, COLLCNT=0, RR pointer=0. Takes effect immediately; release is synchronous to BASECK.
- Latency: 1 cycle. Inputs sampled at edge N appear on ICEDOP/ICEDOPV/GRANT after edge N.
- Sources with ICEDOPVLD[i]=0 are masked to zero and never granted.
- No valid source in a cycle: next ICEDOP=0, ICEDOPV=0, GRANT=0. The bus idles at zero, never holds the last value.
- MODE 00/11 (OR merge):
  - ICEDOP = bitwise OR of all valid sources; ICEDOPV = OR of ICEDOPVLD.
  - Collision event: any pair of valid sources with a nonzero bitwise AND of their data.
- MODE 01 (fixed priority):
  - Lowest-index valid source wins. ICEDOP = its data; GRANT = its one-hot bit.
  - Collision event: two or more sources valid in the same cycle.
- MODE 10 (round-robin):
  - Search starts at pointer P and wraps modulo NSRC; the first valid source wins.
  - After a grant to index k, P <= (k+1) mod NSRC. With no grant, P is unchanged.
  - Wrap: a grant to NSRC-1 sets P=0.
  - Collision event: same as MODE 01.
- Collision accounting:
  - On a collision event, COLL <= 1 and COLLCNT <= COLLCNT+1, saturating at 2^CW-1 (no wrap).
  - CLRERR=1 with no event: COLL <= 0, COLLCNT <= 0.
  - CLRERR=1 and an event in the same cycle: the event wins; COLL <= 1, COLLCNT <= 1.
- MODE change: takes effect on the next sampled cycle. No flush and no bubble. The RR pointer is retained across mode changes and updates only while MODE=10.
- Reset asserted mid-stream: all state clears at once, including the RR pointer and COLLCNT. The first post-reset grant in MODE 10 starts from source 0.
- Backward compatibility: NSRC=2, DW=32, MODE=00, both valids tied 1 gives the same data as the previous generation, delayed by one cycle.

Test Plan:
1. Reset then OR mode: NSRC=2, src0=0x0000_00F0, src1=0x0000_000F, both valid -> next cycle ICEDOP=0x0000_00FF, ICEDOPV=1, COLL=0. Repeat with src1=0x0000_0010 -> COLL=1, COLLCNT=1.
2. Valid masking: src0 valid=0 with data 0xFFFF_FFFF, src1 valid=1 with data 0x1234_5678 -> ICEDOP=0x1234_5678. Both valid=0 -> ICEDOP=0, ICEDOPV=0.
3. Fixed priority, NSRC=4: valid=4'b1010 -> GRANT=4'b0010, ICEDOP=src1 data, COLLCNT increments by 1 per cycle while both are held.
4. Round-robin, NSRC=4, all valid for 6 cycles -> GRANT sequence 0001, 0010, 0100, 1000, 0001, 0010. Then valid=4'b1000 only -> GRANT=1000 and P wraps to 0.
5. Counter saturation and clear, CW=2: 5 consecutive collisions -> COLLCNT=3 (saturated). CLRERR alone -> COLL=0, COLLCNT=0. CLRERR in the same cycle as a collision -> COLL=1, COLLCNT=1.
6. Async reset mid-RR: with P=2, drop RESETB between edges -> outputs 0 immediately. After release with all valid -> first GRANT=0001.
